// File: rtl/gray_counter_if.sv
// Gray-code output channel: registered code plus valid/ready handshake.
// The counter drives the master side; the Gray-to-binary consumer takes the slave side.
interface gray_counter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] gray_out;
    logic             gray_valid;
    logic             gray_ready;

    modport master (
        output gray_out,
        output gray_valid,
        input  gray_ready
    );

    modport slave (
        input  gray_out,
        input  gray_valid,
        output gray_ready
    );
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray-code output behind a valid/ready channel.
// Supports load, wrap or saturate at the range ends, and a terminal-count flag.
module gray_counter #(
    parameter int WIDTH = 8,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc,
    gray_counter_if.master   gif
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] MAX  = '1;

    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             valid_q, valid_d;
    logic             tc_q,    tc_d;
    logic             accept;
    logic             at_end;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] wrap_val;

    // A new update may replace the output only once the old one is taken.
    assign accept = !valid_q || gif.gray_ready;

    assign at_end   = up_dn ? (cnt_q == MAX) : (cnt_q == ZERO);
    assign step_val = up_dn ? (cnt_q + ONE) : (cnt_q - ONE);
    assign wrap_val = up_dn ? ZERO : MAX;

    always_comb begin
        cnt_d   = cnt_q;
        valid_d = valid_q;
        tc_d    = tc_q;
        if (accept) begin
            unique case (1'b1)
                load: begin
                    cnt_d   = load_val;
                    valid_d = 1'b1;
                    tc_d    = 1'b0;
                end
                (en && !load): begin
                    valid_d = 1'b1;
                    if (at_end) begin
                        cnt_d = WRAP ? wrap_val : cnt_q;
                        tc_d  = 1'b1;
                    end else begin
                        cnt_d = step_val;
                        tc_d  = 1'b0;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    tc_d    = 1'b0;
                end
            endcase
        end
    end

    // cnt_d holds when not accepted, so the code tracks it unconditionally.
    assign gray_d = cnt_d ^ (cnt_d >> 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            gray_q  <= '0;
            valid_q <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            gray_q  <= gray_d;
            valid_q <= valid_d;
            tc_q    <= tc_d;
        end
    end

    assign gif.gray_out   = gray_q;
    assign gif.gray_valid = valid_q;
    assign tc             = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: wrapping and saturating instances share stimulus.
// Directed vector table, hand sequences, then random traffic against a model.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       ready = 1'b0;
    logic       tc_w, tc_s;

    int checks = 0;
    int errors = 0;

    gray_counter_if #(.WIDTH(8)) gif_w ();
    gray_counter_if #(.WIDTH(8)) gif_s ();

    assign gif_w.gray_ready = ready;
    assign gif_s.gray_ready = ready;

    gray_counter #(.WIDTH(8), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .tc(tc_w), .gif(gif_w)
    );

    gray_counter #(.WIDTH(8), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .tc(tc_s), .gif(gif_s)
    );

    always #5 clk = ~clk;

    // Reflected-binary table built by mirroring, independent of xor formula.
    int gtab[$];

    typedef struct {
        int cnt;
        bit valid;
        bit tc;
    } mdl_t;

    mdl_t mw, ms;

    function automatic mdl_t mstep(mdl_t m, bit wrap, bit r, bit e,
                                   bit u, bit l, int lv, bit rd);
        mdl_t n;
        int nxt;
        n = m;
        if (!r) begin
            n.cnt = 0; n.valid = 0; n.tc = 0;
            return n;
        end
        if (m.valid && !rd) return n;
        if (l) begin
            n.cnt = lv; n.valid = 1; n.tc = 0;
        end else if (e) begin
            nxt = u ? m.cnt + 1 : m.cnt - 1;
            n.valid = 1;
            if (nxt < 0 || nxt > 255) begin
                n.tc = 1;
                n.cnt = wrap ? (nxt + 256) % 256 : m.cnt;
            end else begin
                n.tc = 0;
                n.cnt = nxt;
            end
        end else begin
            n.valid = 0; n.tc = 0;
        end
        return n;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cmp_models();
        chk("w_gray",  int'(gif_w.gray_out),   gtab[mw.cnt]);
        chk("w_valid", int'(gif_w.gray_valid), int'(mw.valid));
        chk("w_tc",    int'(tc_w),             int'(mw.tc));
        chk("s_gray",  int'(gif_s.gray_out),   gtab[ms.cnt]);
        chk("s_valid", int'(gif_s.gray_valid), int'(ms.valid));
        chk("s_tc",    int'(tc_s),             int'(ms.tc));
    endtask

    task automatic cyc(bit r, bit e, bit u, bit l, logic [7:0] lv, bit rd);
        rst_n = r; en = e; up_dn = u; load = l; load_val = lv; ready = rd;
        @(posedge clk);
        mw = mstep(mw, 1'b1, r, e, u, l, int'(lv), rd);
        ms = mstep(ms, 1'b0, r, e, u, l, int'(lv), rd);
        #1;
        cmp_models();
    endtask

    typedef struct {
        bit         r, e, u, l;
        logic [7:0] lv;
        bit         rd;
        logic [7:0] g;
        bit         v, tc, ob;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [7:0] prev;
        logic [7:0] hold;

        gtab.push_back(0);
        gtab.push_back(1);
        for (int b = 1; b < 8; b++) begin
            int n;
            n = gtab.size();
            for (int i = n - 1; i >= 0; i--)
                gtab.push_back(gtab[i] | (1 << b));
        end
        mw.cnt = 0; mw.valid = 0; mw.tc = 0;
        ms = mw;

        vt.push_back('{0,1,1,1,8'h55,1,8'h00,0,0,0});
        vt.push_back('{0,1,1,1,8'h55,1,8'h00,0,0,0});
        vt.push_back('{1,1,1,0,8'h00,1,8'h01,1,0,1});
        vt.push_back('{1,1,1,0,8'h00,1,8'h03,1,0,1});
        vt.push_back('{1,1,1,0,8'h00,1,8'h02,1,0,1});
        vt.push_back('{1,1,1,0,8'h00,1,8'h06,1,0,1});
        vt.push_back('{1,1,1,0,8'h00,1,8'h07,1,0,1});
        vt.push_back('{1,1,1,0,8'h00,1,8'h05,1,0,1});
        vt.push_back('{1,1,1,0,8'h00,1,8'h04,1,0,1});
        vt.push_back('{1,1,1,0,8'h00,1,8'h0C,1,0,1});
        vt.push_back('{1,1,0,1,8'hFF,1,8'h80,1,0,0});
        vt.push_back('{1,1,1,0,8'h00,1,8'h00,1,1,0});
        vt.push_back('{1,1,1,0,8'h00,1,8'h01,1,0,0});
        vt.push_back('{1,0,1,0,8'h00,1,8'h01,0,0,0});

        @(negedge clk);
        prev = 8'h00;
        foreach (vt[i]) begin
            cyc(vt[i].r, vt[i].e, vt[i].u, vt[i].l, vt[i].lv, vt[i].rd);
            chk("vec_gray",  int'(gif_w.gray_out),   int'(vt[i].g));
            chk("vec_valid", int'(gif_w.gray_valid), int'(vt[i].v));
            chk("vec_tc",    int'(tc_w),             int'(vt[i].tc));
            if (vt[i].ob)
                chk("vec_onebit", $countones(prev ^ gif_w.gray_out), 1);
            prev = gif_w.gray_out;
        end

        // Backpressure: output frozen while valid and not ready.
        cyc(1, 0, 1, 1, 8'h10, 1);
        chk("bp_load", int'(gif_w.gray_out), 'h18);
        hold = 8'h18;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 1, 0, 8'h00, 0);
            chk("bp_hold", int'(gif_w.gray_out), int'(hold));
            chk("bp_tc", int'(tc_w), 0);
        end
        cyc(1, 1, 1, 0, 8'h00, 1);
        chk("bp_res1", int'(gif_w.gray_out), 'h19);
        cyc(1, 1, 1, 0, 8'h00, 1);
        chk("bp_res2", int'(gif_w.gray_out), 'h1B);
        cyc(1, 1, 0, 0, 8'h00, 1);
        chk("dir_chg", int'(gif_w.gray_out), 'h19);

        // Saturate at zero on the WRAP=0 instance; wrap on the other.
        cyc(1, 0, 1, 1, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 8'h00, 1);
            chk("sat_gray", int'(gif_s.gray_out), 0);
            chk("sat_tc", int'(tc_s), 1);
        end
        cyc(1, 1, 1, 0, 8'h00, 1);
        chk("sat_up", int'(gif_s.gray_out), 1);
        chk("sat_up_tc", int'(tc_s), 0);

        // Reset mid-count discards the pending value.
        cyc(1, 0, 1, 1, 8'h2A, 1);
        chk("mid_load", int'(gif_w.gray_out), 'h3F);
        cyc(0, 1, 1, 0, 8'h00, 0);
        chk("mid_rst_g", int'(gif_w.gray_out), 0);
        chk("mid_rst_v", int'(gif_w.gray_valid), 0);
        cyc(1, 1, 1, 0, 8'h00, 0);
        chk("mid_after", int'(gif_w.gray_out), 1);

        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) != 0),
                $urandom_range(0, 3) != 0,
                1'($urandom),
                $urandom_range(0, 7) == 0,
                8'($urandom),
                $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter and code width in bits.
REQ-002 The block SHALL have parameter WRAP, default 1: 1 = wrap at the ends of the range, 0 = saturate at the ends.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: count-step request.
REQ-006 The block SHALL have port up_dn, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-007 The block SHALL have port load, input, 1 bit: load request.
REQ-008 The block SHALL have port load_val, input, WIDTH bits: binary value to load.
REQ-009 The block SHALL have port gray_out, output, WIDTH bits: registered Gray code of the internal count, feeding the downstream Gray-to-binary converter.
REQ-010 The block SHALL have port gray_valid, output, 1 bit: gray_out holds a value the consumer has not yet taken.
REQ-011 The block SHALL have port gray_ready, input, 1 bit: consumer accepts gray_out this cycle.
REQ-012 The block SHALL have port tc, output, 1 bit: terminal-count flag.

Function
REQ-013 The internal count SHALL be held in binary; gray_out SHALL always equal cnt ^ (cnt >> 1), registered.
REQ-014 An update SHALL be accepted in a cycle only when (!gray_valid || gray_ready) is true; otherwise cnt, gray_out, gray_valid and tc SHALL hold.
REQ-015 Update priority SHALL be: load, then en, then idle.
REQ-016 On an accepted load: cnt <= load_val, gray_valid <= 1 and tc <= 0 at the next edge; en and up_dn SHALL be ignored.
REQ-017 On an accepted en step, cnt SHALL change by +1 (up_dn=1) or -1 (up_dn=0), and gray_valid SHALL be set to 1 at the next edge.
REQ-018 With WRAP=1, up from 2^WIDTH-1 SHALL go to 0, and down from 0 SHALL go to 2^WIDTH-1; on either wrap step tc SHALL be 1 for exactly that updated cycle.
REQ-019 With WRAP=0, up at 2^WIDTH-1 and down at 0 SHALL leave cnt unchanged and set tc to 1; tc SHALL stay 1 while such blocked steps continue to be accepted.
REQ-020 tc SHALL clear to 0 on any accepted update that is not a wrap or saturation event.
REQ-021 An accepted cycle with neither load nor en, but with gray_ready=1, SHALL clear gray_valid to 0, hold cnt, and clear tc.
REQ-022 Latency from accepted request to the new gray_out/gray_valid SHALL be exactly 1 cycle; back-to-back steps SHALL be sustainable at 1 per cycle while gray_ready=1.
REQ-023 Consecutive accepted en steps (no load, no saturation) SHALL change gray_out in exactly one bit.
REQ-024 gray_out SHALL NOT change while gray_valid=1 and gray_ready=0.
REQ-025 A direction change between consecutive steps SHALL take effect on the next accepted step with no dead cycle.

Reset
REQ-026 When rst_n=0 at a rising edge: cnt=0, gray_out=0, gray_valid=0, tc=0, regardless of every other input.
REQ-027 Reset asserted mid-operation SHALL discard any pending un-taken value; the first cycle after rst_n returns to 1 SHALL behave as idle with gray_valid=0.

Verification (WIDTH=8 unless stated)
REQ-028 Reset: hold rst_n=0 for 2 cycles with en=1, load=1 -> gray_out=0x00, gray_valid=0, tc=0.
REQ-029 Up-count: gray_ready=1, en=1, up_dn=1 from 0 for 8 cycles -> gray_out = 0x01,0x03,0x02,0x06,0x07,0x05,0x04,0x0C; exactly one bit flips per step; gray_valid=1 throughout.
REQ-030 Wrap: load 0xFF -> gray_out=0x80, tc=0; then one up step -> gray_out=0x00 with tc=1 for one cycle; next step -> gray_out=0x01, tc=0.
REQ-031 Backpressure: gray_valid=1, gray_ready=0, en=1 for 5 cycles -> gray_out and tc frozen; raise gray_ready -> exactly one advance per cycle resumes.
REQ-032 Saturate (WRAP=0): at cnt=0, down steps for 3 cycles -> gray_out stays 0x00, tc=1 each cycle; one up step -> gray_out=0x01, tc=0.
REQ-033 Reset mid-count: at cnt=0x2A (gray_out=0x3F), pulse rst_n=0 for 1 cycle -> gray_out=0x00, gray_valid=0; en=1 afterwards -> gray_out=0x01.
